// File: rtl/debug_scan_pkg.sv
// debug_scan_pkg: shared scan-master states, default sizes and virtual IR encodings
package debug_scan_pkg;
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RSP} scan_state_t;
  localparam int DR_LEN_DEFAULT = 38;
  localparam int IR_LEN_DEFAULT = 2;
  localparam logic [1:0] OCIMEM = 2'b00;
  localparam logic [1:0] TRACEMEM = 2'b01;
  localparam logic [1:0] BREAK = 2'b10;
  localparam logic [1:0] TRACECTRL = 2'b11;
endpackage

// File: rtl/debug_scan_tck_gen.sv
// debug_scan_tck_gen: divides clk into tck while running, with strobes marking the clk edge that raises or drops tck
module debug_scan_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);
  localparam int CW = TCK_DIV > 1 ? $clog2(TCK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(TCK_DIV - 1);
  assign rise = run && last && !tck;
  assign fall = run && last && tck;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      tck <= tck ^ last;
    end
endmodule

// File: rtl/debug_slave_scan_master.sv
// debug_slave_scan_master: runs one IR-update/DR-scan/RTI sequence on the virtual-JTAG nets per command
module debug_slave_scan_master import debug_scan_pkg::*; #(
  parameter int DR_LEN = DR_LEN_DEFAULT,
  parameter int IR_LEN = IR_LEN_DEFAULT,
  parameter int TCK_DIV = 2,
  parameter int RTI_TCKS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IR_LEN-1:0] cmd_ir,
  input  logic [DR_LEN-1:0] cmd_dr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DR_LEN-1:0] rsp_dr,
  output logic              vji_tck,
  output logic              vji_tdi,
  input  logic              vji_tdo,
  output logic [IR_LEN-1:0] vji_ir_in,
  output logic              vji_uir,
  output logic              vji_cdr,
  output logic              vji_sdr,
  output logic              vji_udr,
  output logic              vji_rti
);
  localparam int SMAX = DR_LEN > RTI_TCKS ? DR_LEN : RTI_TCKS;
  localparam int SW = $clog2(SMAX + 1);
  scan_state_t state, state_n;
  logic [SW-1:0] step;
  logic [DR_LEN-1:0] tdi_sr, cap;
  logic [IR_LEN-1:0] ir_q;
  logic rdy_q, run, rise, fall, accept;
  debug_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk(clk), .reset(reset), .run(run), .tck(vji_tck), .rise(rise), .fall(fall)
  );
  // rdy_q keeps cmd_ready low until the first clk after reset releases
  assign cmd_ready = rdy_q && state == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign run = state inside {UIR, CDR, SDR, UDR, RTI};
  assign vji_uir = state == UIR;
  assign vji_cdr = state == CDR;
  assign vji_sdr = state == SDR;
  assign vji_udr = state == UDR;
  assign vji_rti = state == RTI;
  assign vji_tdi = state == SDR && tdi_sr[0];
  assign vji_ir_in = ir_q;
  assign rsp_valid = state == RSP;
  assign rsp_dr = cap;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = accept ? UIR : IDLE;
      UIR:  state_n = fall ? CDR : UIR;
      CDR:  state_n = fall ? SDR : CDR;
      SDR:  state_n = fall && step == SW'(DR_LEN - 1) ? UDR : SDR;
      UDR:  state_n = fall ? RTI : UDR;
      RTI:  state_n = fall && step == SW'(RTI_TCKS - 1) ? RSP : RTI;
      RSP:  state_n = rsp_ready ? IDLE : RSP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      step <= '0;
      tdi_sr <= '0;
      cap <= '0;
      ir_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      state <= state_n;
      step <= state_n != state ? '0 : step + SW'(fall);
      if (accept) begin
        ir_q <= cmd_ir;
        tdi_sr <= cmd_dr;
      end
      if (state == SDR && rise) cap <= {vji_tdo, cap[DR_LEN-1:1]};
      if (state == SDR && fall) tdi_sr <= tdi_sr >> 1;
    end
endmodule

// File: tb/tb_debug_slave_scan_master.sv
// tb_debug_slave_scan_master: directed scans against a 38-bit loopback slave, scoreboarded responses
module tb_debug_slave_scan_master;
  import debug_scan_pkg::*;
  logic clk = 0, reset = 0, cmd_valid = 0, rsp_ready = 1;
  logic [1:0] cmd_ir = '0;
  logic [37:0] cmd_dr = '0;
  logic cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_tdo;
  logic vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [37:0] rsp_dr;
  logic [1:0] vji_ir_in;
  logic [37:0] sr, ld_val = '0;
  logic ld = 0;
  logic [37:0] exp_q[$];
  int checks = 0, errors = 0, pops = 0;
  int c_uir = 0, c_cdr = 0, c_sdr = 0, c_udr = 0, c_rti = 0, c_rise = 0, udr_pulses = 0;
  int b_uir, b_cdr, b_sdr, b_udr, b_rti, b_rise;

  debug_slave_scan_master #(.DR_LEN(38), .IR_LEN(2), .TCK_DIV(1), .RTI_TCKS(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dr(rsp_dr), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  always #5 clk = ~clk;

  // slave model: shifts on tck rise during SDR, tdo presents the pre-shift bit
  assign vji_tdo = sr[0];
  always @(posedge vji_tck or posedge ld)
    if (ld) sr <= ld_val;
    else if (vji_sdr) sr <= {vji_tdi, sr[37:1]};

  always @(posedge vji_tck) begin
    c_rise++;
    if (vji_uir) c_uir++;
    if (vji_cdr) c_cdr++;
    if (vji_sdr) c_sdr++;
    if (vji_udr) c_udr++;
    if (vji_rti) c_rti++;
  end
  always @(posedge vji_udr) udr_pulses++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk)
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      else begin
        chk("rsp_dr", 64'(rsp_dr), 64'(exp_q.pop_front()));
        pops++;
      end
    end

  task automatic preload(input logic [37:0] v);
    ld_val = v;
    ld = 1;
    #1 ld = 0;
  endtask

  task automatic snap();
    b_uir = c_uir; b_cdr = c_cdr; b_sdr = c_sdr; b_udr = c_udr; b_rti = c_rti; b_rise = c_rise;
  endtask

  task automatic steps();
    chk("uir_steps", 64'(c_uir - b_uir), 64'd1);
    chk("cdr_steps", 64'(c_cdr - b_cdr), 64'd1);
    chk("sdr_steps", 64'(c_sdr - b_sdr), 64'd38);
    chk("udr_steps", 64'(c_udr - b_udr), 64'd1);
    chk("rti_steps", 64'(c_rti - b_rti), 64'd2);
    chk("tck_rises", 64'(c_rise - b_rise), 64'd43);
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 64'(n < 500), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic issue(input logic [1:0] ir, input logic [37:0] dr);
    @(negedge clk);
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1;
    wait_accept();
  endtask

  // n counts clk edges after the accept edge until rsp_valid is seen
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!rsp_valid && n < 3000);
    chk("rsp_in_time", 64'(n < 3000), 64'd1);
  endtask

  initial begin
    int n, ok, u0, d0;
    #1 reset = 1;
    #11;
    chk("reset_outputs", {15'd0, cmd_ready, rsp_valid, rsp_dr, vji_tck, vji_tdi, vji_ir_in,
        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 64'd0);
    @(negedge clk) reset = 0;
    #1 chk("ready_before_clk", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1 chk("ready_after_clk", 64'(cmd_ready), 64'd1);

    // loopback scan with latency and step accounting
    preload(38'h15_5555_5555);
    snap();
    exp_q.push_back(38'h15_5555_5555);
    issue(TRACEMEM, 38'h2A_AAAA_AAAA);
    chk("ready_drops", 64'(cmd_ready), 64'd0);
    wait_rsp(n);
    chk("latency_clk", 64'(n + 1), 64'd87);
    chk("ir_in", 64'(vji_ir_in), 64'd1);
    chk("slave_sr", 64'(sr), 64'h2A_AAAA_AAAA);
    steps();
    @(posedge clk);
    #1 chk("ready_after_rsp", 64'(cmd_ready), 64'd1);

    // back-pressure
    rsp_ready = 0;
    preload(38'h01_2345_6789);
    exp_q.push_back(38'h01_2345_6789);
    issue(BREAK, 38'h3F_0000_FFFF);
    wait_rsp(n);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (!rsp_valid || rsp_dr !== 38'h01_2345_6789 || vji_tck || cmd_ready) ok = 0;
    end
    chk("bp_stable", 64'(ok), 64'd1);
    rsp_ready = 1;
    @(posedge clk);
    #1 chk("bp_release", {62'd0, cmd_ready, rsp_valid}, 64'd2);
    chk("bp_slave_sr", 64'(sr), 64'h3F_0000_FFFF);

    // reset in the middle of SDR
    u0 = udr_pulses;
    d0 = c_udr;
    preload(38'h3C_3C3C_3C3C);
    snap();
    issue(OCIMEM, 38'h11_1111_1111);
    n = 0;
    while (c_sdr - b_sdr < 17 && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    chk("sdr17_in_time", 64'(n < 500), 64'd1);
    #1 reset = 1;
    #1 chk("mid_reset_outputs", {59'd0, vji_sdr, vji_tck, rsp_valid, cmd_ready, vji_udr}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    repeat (5) @(posedge clk);
    #1 chk("no_udr_pulse", 64'(udr_pulses - u0 + c_udr - d0), 64'd0);
    chk("ir_after_reset", 64'(vji_ir_in), 64'd0);
    preload(38'h0D_EADB_EEF0);
    snap();
    exp_q.push_back(38'h0D_EADB_EEF0);
    issue(TRACECTRL, 38'h15_0F0F_0F0F);
    wait_rsp(n);
    chk("post_reset_latency", 64'(n + 1), 64'd87);
    chk("post_reset_sr", 64'(sr), 64'h15_0F0F_0F0F);
    steps();

    // second command held during a scan must wait for IDLE
    preload(38'h24_6813_579B);
    exp_q.push_back(38'h24_6813_579B);
    exp_q.push_back(38'h33_CCCC_3333);
    issue(TRACECTRL, 38'h33_CCCC_3333);
    @(negedge clk);
    cmd_ir = OCIMEM;
    cmd_dr = 38'h0A_5A5A_5A5A;
    cmd_valid = 1;
    wait_rsp(n);
    chk("held_ir", 64'(vji_ir_in), 64'd3);
    chk("held_sr", 64'(sr), 64'h33_CCCC_3333);
    chk("held_latency", 64'(n + 1), 64'd87);
    wait_accept();
    wait_rsp(n);
    chk("second_ir", 64'(vji_ir_in), 64'd0);
    chk("second_sr", 64'(sr), 64'h0A_5A5A_5A5A);
    repeat (3) @(posedge clk);
    #1 chk("pops", 64'(pops), 64'd5);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
